// File: rtl/id_ex_fwd_reg_pkg.sv
// Shared constants and helpers for the ID/EX forwarding register and its operand selectors.
package id_ex_fwd_reg_pkg;

    // Widest forwarding-source vector the priority search handles.
    localparam int unsigned MaxFwd = 32;

    // Register id 0 is hard-wired to zero and never takes a forwarded value.
    localparam int unsigned ZeroRegId = 0;

    // A NOP has every control bit clear.
    localparam logic CtrlNopBit = 1'b0;

    // Returns the index of the lowest set bit, which is the youngest matching
    // source. Returns -1 when no bit is set.
    function automatic int prio_first(input logic [MaxFwd-1:0] match);
        prio_first = -1;
        for (int k = MaxFwd - 1; k >= 0; k--) begin
            if (match[k]) begin
                prio_first = k;
            end
        end
    endfunction

endpackage

// File: rtl/id_ex_fwd_reg_fwd_select.sv
// Chooses the operand value for one register id by comparing it against every forwarding source.
// The youngest matching source wins, and a pending winner falls back to the held value.
module fwd_select
    import id_ex_fwd_reg_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RID_W = 5,
    parameter int unsigned NFWD  = 2
) (
    input  logic [RID_W-1:0]      src_id,
    input  logic [XLEN-1:0]       src_val,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_pending,
    input  logic [NFWD*RID_W-1:0] fwd_dst_id,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    output logic [XLEN-1:0]       sel_val,
    output logic                  hit,
    output logic                  pending
);

    logic [NFWD-1:0]   match;
    logic [MaxFwd-1:0] match_ext;
    logic [XLEN-1:0]   win_data;
    logic              win_pend;
    logic              found;
    int                win;

    always_comb begin
        match = '0;
        for (int k = 0; k < NFWD; k++) begin
            match[k] = fwd_valid[k]
                && (fwd_dst_id[k*RID_W +: RID_W] != RID_W'(ZeroRegId))
                && (fwd_dst_id[k*RID_W +: RID_W] == src_id);
        end
        match_ext = '0;
        match_ext[NFWD-1:0] = match;
        win = prio_first(match_ext);

        win_data = '0;
        win_pend = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            if (win == k) begin
                win_data = fwd_data[k*XLEN +: XLEN];
                win_pend = fwd_pending[k];
            end
        end

        // A pending winner still blocks the older sources behind it.
        found   = (win >= 0);
        hit     = found && !win_pend;
        pending = found && win_pend;
        sel_val = hit ? win_data : src_val;
    end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with priority operand forwarding, stall-time refresh of held
// operands, and load-use hazard detection.
module id_ex_fwd_reg
    import id_ex_fwd_reg_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RID_W  = 5,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned NFWD   = 2,
    parameter int unsigned CTRL_W = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  bubble,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [NSRC*RID_W-1:0] in_src_id,
    input  logic [NSRC*XLEN-1:0]  in_src_val,
    input  logic [RID_W-1:0]      in_dst_id,
    input  logic                  in_reg_write,
    input  logic                  in_is_load,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD-1:0]       fwd_pending,
    input  logic [NFWD*RID_W-1:0] fwd_dst_id,
    input  logic [NFWD*XLEN-1:0]  fwd_data,
    output logic                  out_valid,
    output logic [XLEN-1:0]       out_pc,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [RID_W-1:0]      out_dst_id,
    output logic                  out_reg_write,
    output logic                  out_is_load,
    output logic [NSRC*XLEN-1:0]  out_src_val,
    output logic [NSRC-1:0]       fwd_hit,
    output logic                  hazard
);

    logic                  valid_q,     valid_d;
    logic [XLEN-1:0]       pc_q,        pc_d;
    logic [CTRL_W-1:0]     ctrl_q,      ctrl_d;
    logic [NSRC*RID_W-1:0] src_id_q,    src_id_d;
    logic [NSRC*XLEN-1:0]  src_val_q,   src_val_d;
    logic [RID_W-1:0]      dst_id_q,    dst_id_d;
    logic                  reg_write_q, reg_write_d;
    logic                  is_load_q,   is_load_d;

    logic [NSRC*XLEN-1:0]  sel_val;
    logic [NSRC-1:0]       sel_hit;
    logic [NSRC-1:0]       sel_pend;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_select #(
            .XLEN  (XLEN),
            .RID_W (RID_W),
            .NFWD  (NFWD)
        ) u_fwd_select (
            .src_id      (src_id_q[i*RID_W +: RID_W]),
            .src_val     (src_val_q[i*XLEN +: XLEN]),
            .fwd_valid   (fwd_valid),
            .fwd_pending (fwd_pending),
            .fwd_dst_id  (fwd_dst_id),
            .fwd_data    (fwd_data),
            .sel_val     (sel_val[i*XLEN +: XLEN]),
            .hit         (sel_hit[i]),
            .pending     (sel_pend[i])
        );
    end

    always_comb begin
        valid_d     = in_valid;
        pc_d        = in_pc;
        ctrl_d      = in_ctrl;
        src_id_d    = in_src_id;
        src_val_d   = in_src_val;
        dst_id_d    = in_dst_id;
        reg_write_d = in_reg_write;
        is_load_d   = in_is_load;
        if (bubble) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            ctrl_d      = {CTRL_W{CtrlNopBit}};
            src_id_d    = '0;
            src_val_d   = '0;
            dst_id_d    = '0;
            reg_write_d = 1'b0;
            is_load_d   = 1'b0;
        end else if (stall) begin
            valid_d     = valid_q;
            pc_d        = pc_q;
            ctrl_d      = ctrl_q;
            src_id_d    = src_id_q;
            dst_id_d    = dst_id_q;
            reg_write_d = reg_write_q;
            is_load_d   = is_load_q;
            // Capture forwarded results so a producer retiring mid-stall is not lost.
            src_val_d   = sel_val;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            ctrl_q      <= '0;
            src_id_q    <= '0;
            src_val_q   <= '0;
            dst_id_q    <= '0;
            reg_write_q <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            ctrl_q      <= ctrl_d;
            src_id_q    <= src_id_d;
            src_val_q   <= src_val_d;
            dst_id_q    <= dst_id_d;
            reg_write_q <= reg_write_d;
            is_load_q   <= is_load_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = pc_q;
    assign out_ctrl      = ctrl_q;
    assign out_dst_id    = dst_id_q;
    assign out_reg_write = reg_write_q;
    assign out_is_load   = is_load_q;
    assign out_src_val   = sel_val;
    assign fwd_hit       = sel_hit & {NSRC{valid_q}};
    assign hazard        = valid_q && (|sel_pend);

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Directed bench for id_ex_fwd_reg at default parameters (XLEN=32, RID_W=5, NSRC=2, NFWD=2).
module tb_id_ex_fwd_reg;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        bubble;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [7:0]  in_ctrl;
    logic [9:0]  in_src_id;
    logic [63:0] in_src_val;
    logic [4:0]  in_dst_id;
    logic        in_reg_write;
    logic        in_is_load;
    logic [1:0]  fwd_valid;
    logic [1:0]  fwd_pending;
    logic [9:0]  fwd_dst_id;
    logic [63:0] fwd_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [7:0]  out_ctrl;
    logic [4:0]  out_dst_id;
    logic        out_reg_write;
    logic        out_is_load;
    logic [63:0] out_src_val;
    logic [1:0]  fwd_hit;
    logic        hazard;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    id_ex_fwd_reg dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .stall         (stall),
        .bubble        (bubble),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_ctrl       (in_ctrl),
        .in_src_id     (in_src_id),
        .in_src_val    (in_src_val),
        .in_dst_id     (in_dst_id),
        .in_reg_write  (in_reg_write),
        .in_is_load    (in_is_load),
        .fwd_valid     (fwd_valid),
        .fwd_pending   (fwd_pending),
        .fwd_dst_id    (fwd_dst_id),
        .fwd_data      (fwd_data),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_ctrl      (out_ctrl),
        .out_dst_id    (out_dst_id),
        .out_reg_write (out_reg_write),
        .out_is_load   (out_is_load),
        .out_src_val   (out_src_val),
        .fwd_hit       (fwd_hit),
        .hazard        (hazard)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_valid   = '0;
        fwd_pending = '0;
        fwd_dst_id  = '0;
        fwd_data    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; bubble = 0; clear_fwd();
        in_valid = 1; in_pc = 32'h400; in_ctrl = 8'h5A; in_src_id = {5'd2, 5'd1};
        in_src_val = {32'h22, 32'h11}; in_dst_id = 5'd7; in_reg_write = 1; in_is_load = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || hazard !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got v=%b pc=%h hz=%b exp v=0 pc=0 hz=0", out_valid, out_pc, hazard);
        end
        rst = 0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_ctrl !== 8'h5A) begin
            failures++;
            $display("FAIL reset_load got v=%b pc=%h ctrl=%h exp v=1 pc=400 ctrl=5a",
                     out_valid, out_pc, out_ctrl);
        end
        // Make operand 0 look like a pending load hit before the mid-cycle reset.
        fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_dst_id = {5'd0, 5'd1};
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_hazard got=%b exp=1", hazard);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 0 || out_pc !== 0 || out_ctrl !== 0 || out_dst_id !== 0 ||
            out_reg_write !== 0 || out_is_load !== 0 || out_src_val !== 64'h0 ||
            fwd_hit !== 2'b00 || hazard !== 0) begin
            failures++;
            $display("FAIL reset_async got v=%b pc=%h ctrl=%h dst=%h rw=%b ld=%b src=%h hit=%b hz=%b exp all 0",
                     out_valid, out_pc, out_ctrl, out_dst_id, out_reg_write, out_is_load,
                     out_src_val, fwd_hit, hazard);
        end
        clear_fwd();
        #1 rst = 1'b0;
    endtask

    task automatic test_priority();
        in_valid = 1; in_pc = 32'h500; in_ctrl = 8'h01; in_is_load = 0;
        in_src_id = {5'd0, 5'd5}; in_src_val = {32'h11, 32'h99};
        tick();
        fwd_valid = 2'b11; fwd_dst_id = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA};
        #1;
        checks++;
        if (out_src_val[31:0] !== 32'hAAAA || fwd_hit !== 2'b01) begin
            failures++;
            $display("FAIL prio_youngest got val=%h hit=%b exp val=aaaa hit=01", out_src_val[31:0], fwd_hit);
        end
        checks++;
        if (out_src_val[63:32] !== 32'h11) begin
            failures++;
            $display("FAIL prio_zero_src got=%h exp=11", out_src_val[63:32]);
        end
        fwd_valid = 2'b10;
        #1;
        checks++;
        if (out_src_val[31:0] !== 32'hBBBB || fwd_hit !== 2'b01) begin
            failures++;
            $display("FAIL prio_older got val=%h hit=%b exp val=bbbb hit=01", out_src_val[31:0], fwd_hit);
        end
        fwd_valid = 2'b11; fwd_dst_id = {5'd0, 5'd0};
        #1;
        checks++;
        if (out_src_val[31:0] !== 32'h99 || fwd_hit !== 2'b00) begin
            failures++;
            $display("FAIL prio_dst_zero got val=%h hit=%b exp val=99 hit=00", out_src_val[31:0], fwd_hit);
        end
        clear_fwd();
    endtask

    task automatic test_load_use();
        in_valid = 1; in_pc = 32'h600; in_src_id = {5'd8, 5'd0}; in_src_val = {32'hDEAD, 32'h0};
        tick();
        fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_dst_id = {5'd0, 5'd8}; fwd_data = {32'h0, 32'hFFFF};
        #1;
        checks++;
        if (hazard !== 1'b1 || fwd_hit !== 2'b00 || out_src_val[63:32] !== 32'hDEAD) begin
            failures++;
            $display("FAIL lu_hazard got hz=%b hit=%b val=%h exp hz=1 hit=00 val=dead",
                     hazard, fwd_hit, out_src_val[63:32]);
        end
        stall = 1; in_pc = 32'h999; in_src_val = 64'h0;
        tick();
        checks++;
        if (hazard !== 1'b1 || out_pc !== 32'h600 || out_src_val[63:32] !== 32'hDEAD) begin
            failures++;
            $display("FAIL lu_stalled got hz=%b pc=%h val=%h exp hz=1 pc=600 val=dead",
                     hazard, out_pc, out_src_val[63:32]);
        end
        fwd_pending = 2'b00; fwd_data = {32'h0, 32'h1234};
        #1;
        checks++;
        if (hazard !== 1'b0 || out_src_val[63:32] !== 32'h1234 || fwd_hit !== 2'b10) begin
            failures++;
            $display("FAIL lu_resolved got hz=%b val=%h hit=%b exp hz=0 val=1234 hit=10",
                     hazard, out_src_val[63:32], fwd_hit);
        end
        tick();
        clear_fwd();
        #1;
        checks++;
        if (out_src_val[63:32] !== 32'h1234 || out_pc !== 32'h600) begin
            failures++;
            $display("FAIL lu_refreshed got val=%h pc=%h exp val=1234 pc=600", out_src_val[63:32], out_pc);
        end
        stall = 0;
    endtask

    task automatic test_refresh();
        in_valid = 1; in_pc = 32'h700; in_src_id = {5'd0, 5'd3}; in_src_val = {32'h0, 32'h10};
        tick();
        stall = 1; in_src_val = 64'hFFFF_FFFF_FFFF_FFFF;
        fwd_valid = 2'b10; fwd_dst_id = {5'd3, 5'd0}; fwd_data = {32'h55, 32'h0};
        #1;
        checks++;
        if (out_src_val[31:0] !== 32'h55 || fwd_hit !== 2'b01) begin
            failures++;
            $display("FAIL refresh_live got val=%h hit=%b exp val=55 hit=01", out_src_val[31:0], fwd_hit);
        end
        tick();
        clear_fwd();
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (out_src_val[31:0] !== 32'h55 || fwd_hit !== 2'b00) begin
                failures++;
                $display("FAIL refresh_held c=%0d got val=%h hit=%b exp val=55 hit=00",
                         c, out_src_val[31:0], fwd_hit);
            end
        end
        stall = 0;
    endtask

    task automatic test_shadowed();
        in_valid = 1; in_pc = 32'h800; in_src_id = {5'd0, 5'd4}; in_src_val = {32'h0, 32'h20};
        tick();
        fwd_valid = 2'b11; fwd_pending = 2'b10; fwd_dst_id = {5'd4, 5'd4}; fwd_data = {32'h99, 32'h7};
        #1;
        checks++;
        if (hazard !== 1'b0 || out_src_val[31:0] !== 32'h7 || fwd_hit !== 2'b01) begin
            failures++;
            $display("FAIL shadow_hidden got hz=%b val=%h hit=%b exp hz=0 val=7 hit=01",
                     hazard, out_src_val[31:0], fwd_hit);
        end
        fwd_pending = 2'b01;
        #1;
        checks++;
        if (hazard !== 1'b1 || out_src_val[31:0] !== 32'h20 || fwd_hit !== 2'b00) begin
            failures++;
            $display("FAIL shadow_young_pend got hz=%b val=%h hit=%b exp hz=1 val=20 hit=00",
                     hazard, out_src_val[31:0], fwd_hit);
        end
        clear_fwd();
    endtask

    task automatic test_bubble();
        in_valid = 1; in_pc = 32'h900; in_ctrl = 8'hFF; in_dst_id = 5'd9; in_reg_write = 1;
        in_is_load = 1;
        tick();
        checks++;
        if (out_ctrl !== 8'hFF || out_dst_id !== 5'd9 || out_is_load !== 1'b1) begin
            failures++;
            $display("FAIL bubble_pre got ctrl=%h dst=%h ld=%b exp ctrl=ff dst=09 ld=1",
                     out_ctrl, out_dst_id, out_is_load);
        end
        stall = 1; bubble = 1;
        tick();
        checks++;
        if (out_valid !== 0 || out_ctrl !== 0 || out_reg_write !== 0 || out_is_load !== 0 ||
            out_pc !== 0) begin
            failures++;
            $display("FAIL bubble_nop got v=%b ctrl=%h rw=%b ld=%b pc=%h exp all 0",
                     out_valid, out_ctrl, out_reg_write, out_is_load, out_pc);
        end
        stall = 0; bubble = 0;
    endtask

    task automatic test_back_to_back();
        in_is_load = 0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1; in_pc = 32'h100 + 32'(n * 4); in_ctrl = 8'(8'h10 + n);
            in_src_id = {5'd0, 5'd0}; in_src_val = {32'(n), 32'(n * 3)};
            tick();
            checks++;
            if (out_pc !== 32'h100 + 32'(n * 4) || out_ctrl !== 8'(8'h10 + n) ||
                out_src_val !== {32'(n), 32'(n * 3)}) begin
                failures++;
                $display("FAIL b2b n=%0d got pc=%h ctrl=%h src=%h exp pc=%h ctrl=%h src=%h",
                         n, out_pc, out_ctrl, out_src_val, 32'h100 + 32'(n * 4),
                         8'(8'h10 + n), {32'(n), 32'(n * 3)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_load_use();
        test_refresh();
        test_shadowed();
        test_bubble();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
